// File: rtl/execute_stage_pkg.sv
// Shared definitions for the EX stage: ALU operation codes and default datapath width.
package execute_stage_pkg;

  localparam int unsigned N_DEFAULT = 64;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_NOR   = 4'b1100
  } alu_op_e;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the EX stage; unsupported codes yield a zero result.
module execute_stage_alu
  import execute_stage_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   alu_control,
  output logic [N-1:0] result,
  output logic         zero
);

  logic [N-1:0] w_result;

  always_comb begin
    w_result = '0;
    case (alu_control)
      ALU_AND:   w_result = a & b;
      ALU_OR:    w_result = a | b;
      ALU_ADD:   w_result = a + b;
      ALU_SUB:   w_result = a - b;
      ALU_PASSB: w_result = b;
      ALU_NOR:   w_result = ~(a | b);
      default:   w_result = '0;
    endcase
  end

  assign result = w_result;
  assign zero   = (w_result == '0);

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand-B select, ALU, branch-target adder and the EX/MEM pipeline register.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         flush,
  input  logic         alu_src,
  input  logic [3:0]   alu_control,
  input  logic [N-1:0] pc_e,
  input  logic [N-1:0] sign_imm_e,
  input  logic [N-1:0] read_data1_e,
  input  logic [N-1:0] read_data2_e,
  output logic [N-1:0] pc_branch_m,
  output logic [N-1:0] alu_result_m,
  output logic [N-1:0] write_data_m,
  output logic         zero_m
);

  logic [N-1:0] w_src_b;
  logic [N-1:0] w_alu_result;
  logic         w_zero;
  logic [N-1:0] w_pc_branch;

  logic [N-1:0] r_pc_branch;
  logic [N-1:0] r_alu_result;
  logic [N-1:0] r_write_data;
  logic         r_zero;

  assign w_src_b = alu_src ? read_data2_e : sign_imm_e;

  execute_stage_alu #(.N(N)) u_alu (
    .a           (read_data1_e),
    .b           (w_src_b),
    .alu_control (alu_control),
    .result      (w_alu_result),
    .zero        (w_zero)
  );

  // Word offset to byte offset; the top two immediate bits fall off.
  assign w_pc_branch = pc_e + {sign_imm_e[N-3:0], 2'b00};

  // A cleared register is a bubble, so zero_m reads 0 there rather than tracking alu_result_m.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_branch  <= '0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_zero       <= 1'b0;
    end else if (flush) begin
      r_pc_branch  <= '0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_zero       <= 1'b0;
    end else if (en) begin
      r_pc_branch  <= w_pc_branch;
      r_alu_result <= w_alu_result;
      r_write_data <= read_data2_e;
      r_zero       <= w_zero;
    end
  end

  assign pc_branch_m  = r_pc_branch;
  assign alu_result_m = r_alu_result;
  assign write_data_m = r_write_data;
  assign zero_m       = r_zero;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

  localparam int N = 64;
  localparam logic [N-1:0] ONES = {N{1'b1}};

  logic         clk;
  logic         reset;
  logic         en;
  logic         flush;
  logic         alu_src;
  logic [3:0]   alu_control;
  logic [N-1:0] pc_e;
  logic [N-1:0] sign_imm_e;
  logic [N-1:0] read_data1_e;
  logic [N-1:0] read_data2_e;
  logic [N-1:0] pc_branch_m;
  logic [N-1:0] alu_result_m;
  logic [N-1:0] write_data_m;
  logic         zero_m;

  int n_checks = 0;
  int n_errors = 0;

  execute_stage #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .flush        (flush),
    .alu_src      (alu_src),
    .alu_control  (alu_control),
    .pc_e         (pc_e),
    .sign_imm_e   (sign_imm_e),
    .read_data1_e (read_data1_e),
    .read_data2_e (read_data2_e),
    .pc_branch_m  (pc_branch_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .zero_m       (zero_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic src, input logic [3:0] ctl, input logic [N-1:0] pc,
                       input logic [N-1:0] imm, input logic [N-1:0] a, input logic [N-1:0] b);
    alu_src      = src;
    alu_control  = ctl;
    pc_e         = pc;
    sign_imm_e   = imm;
    read_data1_e = a;
    read_data2_e = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    flush = 1'b0;
    drive(1'b1, 4'b0010, 64'd15, 64'd2, 64'd23, 64'd32);
    #12;
    chk("rst_pcb",  pc_branch_m,  '0);
    chk("rst_alu",  alu_result_m, '0);
    chk("rst_wd",   write_data_m, '0);
    chk("rst_zero", {63'd0, zero_m}, 64'd0);
    reset = 1'b0;
    en    = 1'b1;
    step();

    chk("add_alu",  alu_result_m, 64'd55);
    chk("add_zero", {63'd0, zero_m}, 64'd0);
    chk("add_wd",   write_data_m, 64'd32);
    chk("br_15_2",  pc_branch_m,  64'd23);

    drive(1'b1, 4'b0111, 64'd100, ONES, 64'd9, 64'h55);
    step();
    chk("br_neg1",  pc_branch_m,  64'd96);
    chk("passb",    alu_result_m, 64'h55);

    drive(1'b0, 4'b0010, 64'd0, 64'd23, 64'd23, 64'd99);
    step();
    chk("imm_add",  alu_result_m, 64'd46);
    chk("imm_wd",   write_data_m, 64'd99);
    chk("imm_pcb",  pc_branch_m,  64'd92);

    drive(1'b1, 4'b0110, 64'd0, 64'd0, 64'd7, 64'd7);
    step();
    chk("sub_alu",  alu_result_m, 64'd0);
    chk("sub_zero", {63'd0, zero_m}, 64'd1);

    drive(1'b1, 4'b0000, 64'd0, 64'd0, 64'hF0, 64'h3C);
    step();
    chk("and_alu",  alu_result_m, 64'h30);
    chk("and_zero", {63'd0, zero_m}, 64'd0);

    drive(1'b1, 4'b0001, 64'd0, 64'd0, 64'hF0, 64'h3C);
    step();
    chk("or_alu",   alu_result_m, 64'hFC);

    drive(1'b1, 4'b1100, 64'd0, 64'd0, 64'd0, 64'd0);
    step();
    chk("nor_alu",  alu_result_m, ONES);
    chk("nor_zero", {63'd0, zero_m}, 64'd0);

    drive(1'b1, 4'b1111, 64'd0, 64'd0, 64'd5, 64'd6);
    step();
    chk("bad_alu",  alu_result_m, 64'd0);
    chk("bad_zero", {63'd0, zero_m}, 64'd1);

    drive(1'b1, 4'b0010, 64'd0, 64'd0, ONES, 64'd1);
    step();
    chk("wrap_alu", alu_result_m, 64'd0);
    chk("wrap_zero", {63'd0, zero_m}, 64'd1);

    drive(1'b1, 4'b0010, 64'd40, 64'd1, 64'd1, 64'd2);
    step();
    chk("cap_alu",  alu_result_m, 64'd3);
    en = 1'b0;
    drive(1'b1, 4'b0010, 64'd80, 64'd3, 64'd10, 64'd20);
    step();
    step();
    chk("stall_alu", alu_result_m, 64'd3);
    chk("stall_wd",  write_data_m, 64'd2);
    chk("stall_pcb", pc_branch_m,  64'd44);

    en    = 1'b1;
    flush = 1'b1;
    drive(1'b1, 4'b0110, 64'd80, 64'd3, 64'd10, 64'd10);
    step();
    chk("fl_pcb",  pc_branch_m,  '0);
    chk("fl_alu",  alu_result_m, '0);
    chk("fl_wd",   write_data_m, '0);
    chk("fl_zero", {63'd0, zero_m}, 64'd0);
    flush = 1'b0;

    drive(1'b1, 4'b0001, 64'd8, 64'd4, 64'h1, 64'h6);
    step();
    chk("pre_rst_alu", alu_result_m, 64'h7);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_pcb", pc_branch_m,  '0);
    chk("arst_alu", alu_result_m, '0);
    chk("arst_wd",  write_data_m, '0);
    #1;
    reset = 1'b0;
    drive(1'b1, 4'b0010, 64'd4, 64'd1, 64'd100, 64'd11);
    step();
    chk("post_alu", alu_result_m, 64'd111);
    chk("post_pcb", pc_branch_m,  64'd8);
    chk("post_wd",  write_data_m, 64'd11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
